// File: rtl/si_pkg.sv
// Shared constants and types for the shooter game blocks.
package si_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // Player sprite width, used to centre anything launched from the player.
  localparam int unsigned PLAYER_W = 32;

  // USB HID keycode for the space bar.
  localparam logic [7:0] FIRE_KEY = 8'h2C;

  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    COOLDOWN
  } bullet_state_t;

endpackage

// File: rtl/player_bullet_if.sv
// Signal bundle between the game logic and the player bullet block.
interface player_bullet_if;

  logic       vs;
  logic [7:0] keycode;
  logic       is_playing;
  logic [9:0] player_x;
  logic       hit;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic       bullet_active;
  logic       bullet_on;
  logic       shot_done;
  logic       shot_hit;

  modport master (
    output vs, keycode, is_playing, player_x, hit, DrawX, DrawY,
    input  bullet_x, bullet_y, bullet_active, bullet_on, shot_done, shot_hit
  );

  modport slave (
    input  vs, keycode, is_playing, player_x, hit, DrawX, DrawY,
    output bullet_x, bullet_y, bullet_active, bullet_on, shot_done, shot_hit
  );

endinterface

// File: rtl/frame_tick_gen.sv
// One-cycle pulse on each rising edge of the (already synchronous) vertical sync.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic vs,
  output logic tick
);

  logic vs_q;

  // Remember last vs level for edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) vs_q <= 1'b0;
    else       vs_q <= vs;
  end

  assign tick = vs & ~vs_q;

endmodule

// File: rtl/player_bullet.sv
// Player projectile: fire latch, spawn above the player, per-frame climb,
// retire on hit or screen top, then a frame-counted cooldown before re-arm.
module player_bullet #(
  parameter int unsigned BULLET_W        = 2,
  parameter int unsigned BULLET_H        = 8,
  parameter int unsigned PLAYER_W        = si_pkg::PLAYER_W,
  parameter int unsigned SPAWN_Y         = 440,
  parameter int unsigned SPEED           = 4,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter logic [7:0]  FIRE_KEY        = si_pkg::FIRE_KEY
) (
  input logic           Clk,
  input logic           Reset,
  player_bullet_if.slave bus
);

  import si_pkg::*;

  localparam logic [10:0] X_MAX = 11'(SCREEN_W - BULLET_W);

  logic          tick;
  logic [7:0]    key_q;
  logic          key_edge, fire_req;
  logic          fire_q, fire_d;
  bullet_state_t state_q, state_d;
  logic [9:0]    bx_q, bx_d, by_q, by_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          active_q;
  logic          done_q, done_d, shit_q, shit_d;
  logic [10:0]   spawn_sum, spawn_x;
  logic [10:0]   dx, dy, bx_w, by_w;

  frame_tick_gen u_tick (
    .Clk   (Clk),
    .Reset (Reset),
    .vs    (bus.vs),
    .tick  (tick)
  );

  assign key_edge = (bus.keycode == FIRE_KEY) && (key_q != FIRE_KEY);
  // A press landing on the tick cycle itself still counts.
  assign fire_req = fire_q | key_edge;

  // Centre over the player, keep the whole bullet on screen.
  assign spawn_sum = {1'b0, bus.player_x} + 11'(PLAYER_W / 2) - 11'(BULLET_W / 2);
  assign spawn_x   = (spawn_sum > X_MAX) ? X_MAX : spawn_sum;

  // Next-state logic; leaving play overrides hit and tick.
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    shit_d  = 1'b0;
    fire_d  = tick ? 1'b0 : fire_req;

    if (!bus.is_playing) begin
      state_d = IDLE;
      cnt_d   = '0;
      fire_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tick && fire_req) begin
            state_d = FLYING;
            bx_d    = spawn_x[9:0];
            by_d    = 10'(SPAWN_Y);
          end
        end
        FLYING: begin
          if (bus.hit) begin
            state_d = COOLDOWN;
            cnt_d   = 8'(COOLDOWN_FRAMES);
            done_d  = 1'b1;
            shit_d  = 1'b1;
          end else if (tick) begin
            if (by_q < 10'(SPEED)) begin
              state_d = COOLDOWN;
              cnt_d   = 8'(COOLDOWN_FRAMES);
              done_d  = 1'b1;
            end else begin
              by_d = by_q - 10'(SPEED);
            end
          end
        end
        COOLDOWN: begin
          // A zero count re-arms on the first tick, same as a count of one.
          if (tick) begin
            if (cnt_q <= 8'd1) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      bx_q     <= '0;
      by_q     <= '0;
      cnt_q    <= '0;
      fire_q   <= 1'b0;
      key_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      shit_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      cnt_q    <= cnt_d;
      fire_q   <= fire_d;
      key_q    <= bus.keycode;
      active_q <= (state_d == FLYING);
      done_q   <= done_d;
      shit_q   <= shit_d;
    end
  end

  assign dx   = {1'b0, bus.DrawX};
  assign dy   = {1'b0, bus.DrawY};
  assign bx_w = {1'b0, bx_q};
  assign by_w = {1'b0, by_q};

  assign bus.bullet_x      = bx_q;
  assign bus.bullet_y      = by_q;
  assign bus.bullet_active = active_q;
  assign bus.shot_done     = done_q;
  assign bus.shot_hit      = shit_q;
  assign bus.bullet_on     = active_q
                             && (dx >= bx_w) && (dx < bx_w + 11'(BULLET_W))
                             && (dy >= by_w) && (dy < by_w + 11'(BULLET_H));

endmodule

// File: tb/tb_player_bullet.sv
// Scoreboarded bench for player_bullet: a frame-level reference model queues
// expected spawn/retire events; a monitor pops them when the DUT shows one.
module tb_player_bullet;

  logic Clk = 1'b0;
  logic Reset;

  player_bullet_if bus ();

  player_bullet dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit is_done;
    int x;
    int y;
    bit hit;
  } ev_t;

  ev_t exp_q[$];
  ev_t e;
  int  checks = 0;
  int  errors = 0;
  int  spawns = 0;
  int  last_done_y = -1;
  int  last_done_hit = -1;
  bit  prev_active = 1'b0;

  // Reference model state.
  bit         m_vs_q;
  logic [7:0] m_key_q;
  bit         m_req;
  int         m_mode;  // 0 idle, 1 flying, 2 cooling down
  int         m_x, m_y, m_cool;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_vs_q = 0; m_key_q = 8'h00; m_req = 0; m_mode = 0; m_x = 0; m_y = 0; m_cool = 0;
  endfunction

  function automatic bit model_on(input int dx, input int dy);
    return (m_mode == 1) && dx >= m_x && dx < m_x + 2 && dy >= m_y && dy < m_y + 8;
  endfunction

  // What the DUT does at the coming clock edge given the inputs now driven.
  task automatic model_step();
    bit tick, edge_k, fire;
    tick   = bus.vs && !m_vs_q;
    edge_k = (bus.keycode == 8'h2C) && (m_key_q != 8'h2C);
    if (!bus.is_playing) begin
      m_mode = 0; m_cool = 0; m_req = 0;
    end else begin
      fire = m_req || edge_k;
      case (m_mode)
        0: if (tick && fire) begin
          m_x = int'(bus.player_x) + 15;
          if (m_x > 638) m_x = 638;
          m_y = 440;
          m_mode = 1;
          exp_q.push_back('{1'b0, m_x, m_y, 1'b0});
        end
        1: if (bus.hit) begin
          exp_q.push_back('{1'b1, m_x, m_y, 1'b1});
          m_mode = 2; m_cool = 8;
        end else if (tick) begin
          if (m_y < 4) begin
            exp_q.push_back('{1'b1, m_x, m_y, 1'b0});
            m_mode = 2; m_cool = 8;
          end else begin
            m_y -= 4;
          end
        end
        default: if (tick) begin
          m_cool--;
          if (m_cool == 0) m_mode = 0;
        end
      endcase
      m_req = tick ? 1'b0 : fire;
    end
    m_vs_q  = bus.vs;
    m_key_q = bus.keycode;
  endtask

  task automatic cyc(input bit vs, input logic [7:0] key, input bit play, input int px,
                     input bit hit, input int dx = -1, input int dy = -1);
    int dxv, dyv;
    @(negedge Clk);
    bus.vs = vs; bus.keycode = key; bus.is_playing = play;
    bus.player_x = 10'(px); bus.hit = hit;
    if (dx >= 0) dxv = dx;
    else if ($urandom_range(0, 1) == 1) dxv = m_x + int'($urandom_range(0, 3)) - 1;
    else dxv = int'($urandom_range(0, 639));
    if (dy >= 0) dyv = dy;
    else if ($urandom_range(0, 1) == 1) dyv = m_y + int'($urandom_range(0, 9)) - 1;
    else dyv = int'($urandom_range(0, 479));
    if (dxv < 0) dxv = 0;
    if (dyv < 0) dyv = 0;
    bus.DrawX = 10'(dxv); bus.DrawY = 10'(dyv);
    #1;
    check("bullet_on", int'(bus.bullet_on), int'(model_on(dxv, dyv)));
    check("bullet_active", int'(bus.bullet_active), int'(m_mode == 1));
    if (m_mode == 1) begin
      check("bullet_x", int'(bus.bullet_x), m_x);
      check("bullet_y", int'(bus.bullet_y), m_y);
    end
    model_step();
  endtask

  // Six-cycle frame, vs high for the first two; the first cycle carries the tick.
  task automatic frame(input logic [7:0] key, input bit play, input int px, input int hit_idx);
    for (int i = 0; i < 6; i++) cyc(i < 2, key, play, px, i == hit_idx);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, int'(bus.bullet_x), 0);
    check({tag, "_y"}, int'(bus.bullet_y), 0);
    check({tag, "_active"}, int'(bus.bullet_active), 0);
    check({tag, "_done"}, int'(bus.shot_done), 0);
    check({tag, "_hit"}, int'(bus.shot_hit), 0);
  endtask

  task automatic do_reset_mid();
    @(negedge Clk);
    #3 Reset = 1'b1;
    #1 check_all_zero("rst_async");
    @(posedge Clk);
    #1 check_all_zero("rst_next");
    model_reset();
    exp_q.delete();
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Monitor: pop an expected event whenever the DUT spawns or retires a shot.
  always @(negedge Clk) begin
    if (Reset) begin
      prev_active = 1'b0;
    end else begin
      if (bus.bullet_active && !prev_active) spawns++;
      if (bus.shot_done || (bus.bullet_active && !prev_active)) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event got done=%0d active=%0d expected no event",
                   bus.shot_done, bus.bullet_active);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", int'(bus.shot_done), int'(e.is_done));
          check("event_x", int'(bus.bullet_x), e.x);
          check("event_y", int'(bus.bullet_y), e.y);
          if (e.is_done) begin
            check("shot_hit", int'(bus.shot_hit), int'(e.hit));
            check("active_after_done", int'(bus.bullet_active), 0);
            last_done_y   = int'(bus.bullet_y);
            last_done_hit = int'(bus.shot_hit);
          end
        end
      end
      if (!bus.shot_done) check("shot_hit_without_done", int'(bus.shot_hit), 0);
      prev_active = bus.bullet_active;
    end
  end

  int s0;
  int on_tab[6][3] = '{'{638, 440, 1}, '{639, 447, 1}, '{637, 440, 0},
                       '{638, 448, 0}, '{639, 439, 0}, '{640, 444, 0}};

  initial begin
    Reset = 1'b1;
    bus.vs = 0; bus.keycode = 8'h00; bus.is_playing = 0; bus.player_x = '0;
    bus.hit = 0; bus.DrawX = '0; bus.DrawY = '0;
    model_reset();
    #1 check_all_zero("reset");
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    // Spawn over player at x=100, climb 10 frames, then reset mid-flight at y=200.
    frame(8'h00, 1, 100, -1);
    frame(8'h2C, 1, 100, -1);
    check("spawn_x", int'(bus.bullet_x), 115);
    check("spawn_y", int'(bus.bullet_y), 440);
    repeat (10) frame(8'h00, 1, 100, -1);
    check("y_after_10", int'(bus.bullet_y), 400);
    repeat (50) frame(8'h00, 1, 100, -1);
    check("y_before_reset", int'(bus.bullet_y), 200);
    do_reset_mid();

    // Holding the fire key yields one shot which runs off the top.
    s0 = spawns;
    repeat (200) frame(8'h2C, 1, 100, -1);
    check("hold_one_shot", spawns - s0, 1);
    check("miss_done_y", last_done_y, 0);
    check("miss_done_hit", last_done_hit, 0);

    // Hit coinciding with a tick at y=300, then cooldown gating of new shots.
    frame(8'h00, 1, 200, -1);
    frame(8'h2C, 1, 200, -1);
    repeat (35) frame(8'h00, 1, 200, -1);
    check("y_before_hit", int'(bus.bullet_y), 300);
    frame(8'h00, 1, 200, 0);
    check("hit_done_y", last_done_y, 300);
    check("hit_done_hit", last_done_hit, 1);
    check("hit_y_frozen", int'(bus.bullet_y), 300);
    s0 = spawns;
    frame(8'h00, 1, 200, -1);
    frame(8'h00, 1, 200, -1);
    frame(8'h2C, 1, 200, -1);
    check("fire_in_cooldown", spawns - s0, 0);
    repeat (5) frame(8'h00, 1, 200, -1);
    frame(8'h2C, 1, 200, -1);
    check("fire_after_cooldown", spawns - s0, 1);

    // Dropping play mid-flight, then mid-cooldown; each re-fire spawns at once.
    frame(8'h00, 1, 200, -1);
    cyc(0, 8'h00, 0, 200, 0);
    @(posedge Clk);
    #1 check("drop_flight_active", int'(bus.bullet_active), 0);
    s0 = spawns;
    frame(8'h2C, 1, 200, -1);
    check("refire_after_drop", spawns - s0, 1);
    frame(8'h00, 1, 200, 3);
    cyc(0, 8'h00, 0, 200, 0);
    frame(8'h2C, 1, 200, -1);
    check("refire_after_cool_drop", spawns - s0, 2);

    // Right-edge clamp and pixel coverage boundaries.
    cyc(0, 8'h00, 0, 630, 0);
    frame(8'h00, 1, 630, -1);
    cyc(1, 8'h2C, 1, 630, 0);
    cyc(0, 8'h2C, 1, 630, 0);
    check("clamp_x", int'(bus.bullet_x), 638);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 8'h2C, 1, 630, 0, on_tab[i][0], on_tab[i][1]);
      check("bullet_on_edge", int'(bus.bullet_on), on_tab[i][2]);
    end

    // Randomised play.
    for (int f = 0; f < 300; f++) begin
      logic [7:0] k;
      int sel;
      sel = int'($urandom_range(0, 3));
      k = (sel == 0) ? 8'h2C : (sel == 1) ? 8'h1A : 8'h00;
      frame(k, $urandom_range(0, 29) != 0, int'($urandom_range(0, 639)),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1);
    end
    repeat (2) frame(8'h00, 0, 0, -1);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
